// File: rtl/mem_access_stage_if.sv
// Bundle of the execute-side, data-memory and writeback handshakes of the memory-access stage.
interface mem_access_stage_if #(
  parameter int unsigned N = 32
);
  logic         ex_valid;
  logic         ex_ready;
  logic [6:0]   ex_opcode;
  logic [2:0]   ex_funct3;
  logic [N-1:0] ex_alu_result;
  logic [N-1:0] ex_rs2_data;
  logic [4:0]   ex_rd;

  logic         dmem_req;
  logic         dmem_we;
  logic [N-1:0] dmem_addr;
  logic [3:0]   dmem_be;
  logic [N-1:0] dmem_wdata;
  logic         dmem_gnt;
  logic         dmem_rvalid;
  logic [N-1:0] dmem_rdata;

  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_rd;
  logic [N-1:0] wb_data;
  logic         wb_reg_write;
  logic         wb_misalign;

  modport slave (
    input  ex_valid, ex_opcode, ex_funct3, ex_alu_result, ex_rs2_data, ex_rd,
    output ex_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output wb_valid, wb_rd, wb_data, wb_reg_write, wb_misalign,
    input  wb_ready
  );

  modport master (
    output ex_valid, ex_opcode, ex_funct3, ex_alu_result, ex_rs2_data, ex_rd,
    input  ex_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  wb_valid, wb_rd, wb_data, wb_reg_write, wb_misalign,
    output wb_ready
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores from the ALU result, aligns/extends load
// data and presents one registered result per instruction to writeback.
module mem_access_stage #(
  parameter int unsigned N = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_stage_if.slave bus
);
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRegReg = 7'b0110011;
  localparam logic [6:0] OpRegImm = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

  state_e state_q, state_d;

  logic [N-1:2] addr_q;
  logic [1:0]   off_q;
  logic [2:0]   funct3_q;
  logic         store_q;
  logic [4:0]   rd_q;
  logic [3:0]   be_q;
  logic [N-1:0] wdata_q;

  logic         wb_valid_q, wb_reg_write_q, wb_misalign_q;
  logic [4:0]   wb_rd_q;
  logic [N-1:0] wb_data_q;

  logic         out_free, ex_ready, accept, capture, load_out;
  logic [N-1:0] out_data;
  logic [4:0]   out_rd;
  logic         out_rw, out_mis;

  logic         is_load, is_store, misalign, writes_rd;
  logic [1:0]   ex_off;
  logic [3:0]   st_be;
  logic [N-1:0] st_wdata, rshift, load_data;

  // Decode of the incoming execute result.
  always_comb begin
    is_load   = (bus.ex_opcode == OpLoad);
    is_store  = (bus.ex_opcode == OpStore);
    ex_off    = bus.ex_alu_result[1:0];
    writes_rd = (bus.ex_opcode inside {OpRegReg, OpRegImm, OpJal, OpJalr});
    misalign  = 1'b0;
    if (is_load) begin
      case (bus.ex_funct3)
        3'd0, 3'd4: misalign = 1'b0;
        3'd1, 3'd5: misalign = ex_off[0];
        3'd2:       misalign = (ex_off != 2'b00);
        default:    misalign = 1'b1;
      endcase
    end else if (is_store) begin
      case (bus.ex_funct3)
        3'd0:    misalign = 1'b0;
        3'd1:    misalign = ex_off[0];
        3'd2:    misalign = (ex_off != 2'b00);
        default: misalign = 1'b1;
      endcase
    end
    case (bus.ex_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ex_off;
        st_wdata = {4{bus.ex_rs2_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {ex_off[1], 1'b0};
        st_wdata = {2{bus.ex_rs2_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = bus.ex_rs2_data;
      end
    endcase
  end

  // Load data alignment: shift the addressed lane down, then extend.
  always_comb begin
    rshift = bus.dmem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    load_data = {{(N-8){rshift[7]}}, rshift[7:0]};
      3'd1:    load_data = {{(N-16){rshift[15]}}, rshift[15:0]};
      3'd4:    load_data = {{(N-8){1'b0}}, rshift[7:0]};
      3'd5:    load_data = {{(N-16){1'b0}}, rshift[15:0]};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_free = !wb_valid_q || bus.wb_ready;
    ex_ready = (state_q == StIdle) && out_free;
    accept   = bus.ex_valid && ex_ready;
    capture  = 1'b0;
    load_out = 1'b0;
    out_data = '0;
    out_rd   = rd_q;
    out_rw   = 1'b0;
    out_mis  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if ((is_load || is_store) && !misalign) begin
            capture = 1'b1;
            state_d = StReq;
          end else begin
            load_out = 1'b1;
            out_data = bus.ex_alu_result;
            out_rd   = bus.ex_rd;
            out_mis  = misalign;
            out_rw   = writes_rd && (bus.ex_rd != 5'd0);
          end
        end
      end
      StReq: begin
        if (bus.dmem_gnt) begin
          if (store_q) begin
            load_out = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d  = StWaitR;
          end
        end
      end
      StWaitR: begin
        if (bus.dmem_rvalid) begin
          load_out = 1'b1;
          out_data = load_data;
          out_rw   = (rd_q != 5'd0);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      rd_q     <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else if (capture) begin
      addr_q   <= bus.ex_alu_result[N-1:2];
      off_q    <= ex_off;
      funct3_q <= bus.ex_funct3;
      store_q  <= is_store;
      rd_q     <= bus.ex_rd;
      be_q     <= is_store ? st_be : 4'b1111;
      wdata_q  <= is_store ? st_wdata : '0;
    end
  end

  // Completion always finds the entry free, so load_out takes priority over draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_reg_write_q <= 1'b0;
      wb_misalign_q  <= 1'b0;
    end else if (load_out) begin
      wb_valid_q     <= 1'b1;
      wb_rd_q        <= out_rd;
      wb_data_q      <= out_data;
      wb_reg_write_q <= out_rw;
      wb_misalign_q  <= out_mis;
    end else if (bus.wb_ready) begin
      wb_valid_q     <= 1'b0;
    end
  end

  assign bus.ex_ready     = ex_ready;
  assign bus.dmem_req     = (state_q == StReq);
  assign bus.dmem_we      = store_q;
  assign bus.dmem_addr    = {addr_q, 2'b00};
  assign bus.dmem_be      = be_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.wb_misalign  = wb_misalign_q;
endmodule
